// File: rtl/me_pkg.sv
// Shared types and default sizes for the motion-estimation full-search scheduler.
package me_pkg;

  localparam int DEF_SAD_W    = 16;
  localparam int DEF_MV_W     = 6;
  localparam int DEF_PIPE_LAT = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // valid sits in the MSB so a tag is easy to read in a waveform.
  typedef struct packed {
    logic                       valid;
    logic signed [DEF_MV_W-1:0] x;
    logic signed [DEF_MV_W-1:0] y;
  } tag_t;

endpackage

// File: rtl/me_tag_delay.sv
// Free-running tag shift register that mirrors the SAD adder-tree latency so each
// SAD leaving the tree can be paired with the vector that produced it.
module me_tag_delay
  import me_pkg::*;
#(
  parameter int  PIPE_LAT = DEF_PIPE_LAT,
  parameter type tag_t    = me_pkg::tag_t
) (
  input  logic clk,
  input  logic rst,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stage [PIPE_LAT];

  // NOTE: a short shift register may be fully reset; a RAM-backed history could not be.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < PIPE_LAT; i++) stage[i] <= '0;
    end else begin
      // NOTE: non-blocking so every stage samples the previous stage's old value.
      stage[0] <= tag_in;
      for (int i = 1; i < PIPE_LAT; i++) stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[PIPE_LAT-1];

  // Only tags still travelling count; the exiting tag is captured in this same cycle.
  always_comb begin
    // NOTE: default first so the OR-reduction never infers a latch.
    any_valid = 1'b0;
    for (int i = 0; i < PIPE_LAT - 1; i++) any_valid = any_valid | stage[i].valid;
  end

endmodule

// File: rtl/me_search_ctrl.sv
// Full-search motion-estimation scheduler: issues every candidate vector in raster
// order, pairs returning SADs with their vectors and keeps the minimum.
module me_search_ctrl
  import me_pkg::*;
#(
  parameter int RANGE    = 16,
  parameter int MV_W     = DEF_MV_W,
  parameter int SAD_W    = DEF_SAD_W,
  parameter int PIPE_LAT = DEF_PIPE_LAT
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    cand_valid,
  input  logic                    cand_ready,
  output logic signed [MV_W-1:0]  cand_x,
  output logic signed [MV_W-1:0]  cand_y,
  input  logic        [SAD_W-1:0] sum_in,
  output logic        [SAD_W-1:0] best_sad,
  output logic signed [MV_W-1:0]  best_mvx,
  output logic signed [MV_W-1:0]  best_mvy
);

  typedef struct packed {
    logic                   valid;
    logic signed [MV_W-1:0] x;
    logic signed [MV_W-1:0] y;
  } mv_tag_t;

  localparam logic signed [MV_W-1:0] MV_MIN = MV_W'(-RANGE);
  localparam logic signed [MV_W-1:0] MV_MAX = MV_W'(RANGE - 1);
  localparam logic signed [MV_W-1:0] MV_ONE = MV_W'(1);

  state_t  state;
  logic    first;
  logic    accept;
  logic    capture;
  logic    in_flight;
  mv_tag_t tag_in;
  mv_tag_t tag_out;

  assign accept = cand_valid && cand_ready;
  assign tag_in = '{valid: accept, x: cand_x, y: cand_y};

  me_tag_delay #(
    .PIPE_LAT (PIPE_LAT),
    .tag_t    (mv_tag_t)
  ) u_tag_delay (
    .clk       (clk),
    .rst       (rst),
    .tag_in    (tag_in),
    .tag_out   (tag_out),
    .any_valid (in_flight)
  );

  // Strict less-than keeps the earlier raster candidate on ties.
  assign capture = tag_out.valid && (first || (sum_in < best_sad));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      cand_valid <= 1'b0;
      cand_x     <= '0;
      cand_y     <= '0;
      best_sad   <= '0;
      best_mvx   <= '0;
      best_mvy   <= '0;
      first      <= 1'b0;
    end else begin
      done <= 1'b0;

      if (capture) begin
        best_sad <= sum_in;
        best_mvx <= tag_out.x;
        best_mvy <= tag_out.y;
        first    <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (start) begin
            state      <= ISSUE;
            busy       <= 1'b1;
            cand_valid <= 1'b1;
            cand_x     <= MV_MIN;
            cand_y     <= MV_MIN;
            first      <= 1'b1;
          end
        end

        ISSUE: begin
          if (accept) begin
            if (cand_x == MV_MAX) begin
              cand_x <= MV_MIN;
              if (cand_y == MV_MAX) begin
                cand_valid <= 1'b0;
                state      <= DRAIN;
              end else begin
                cand_y <= cand_y + MV_ONE;
              end
            end else begin
              cand_x <= cand_x + MV_ONE;
            end
          end
        end

        // The final tag is at the delay-line output when nothing else is in flight,
        // so its capture lands on the same edge that enters DONE.
        DRAIN: begin
          if (!in_flight) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end

        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_me_search_ctrl.sv
// Directed bench for me_search_ctrl with a small window: emulates the SAD pipeline
// and checks every cycle against a raster-order candidate model.
module tb_me_search_ctrl;

  localparam int RANGE = 2;
  localparam int MV_W  = 6;
  localparam int SAD_W = 16;
  localparam int P     = 6;
  localparam int SIDE  = 2 * RANGE;
  localparam int NCAND = SIDE * SIDE;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start;
  logic                    busy;
  logic                    done;
  logic                    cand_valid;
  logic                    cand_ready;
  logic signed [MV_W-1:0]  cand_x;
  logic signed [MV_W-1:0]  cand_y;
  logic        [SAD_W-1:0] sum_in;
  logic        [SAD_W-1:0] best_sad;
  logic signed [MV_W-1:0]  best_mvx;
  logic signed [MV_W-1:0]  best_mvy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  me_search_ctrl #(
    .RANGE    (RANGE),
    .MV_W     (MV_W),
    .SAD_W    (SAD_W),
    .PIPE_LAT (P)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .cand_valid (cand_valid),
    .cand_ready (cand_ready),
    .cand_x     (cand_x),
    .cand_y     (cand_y),
    .sum_in     (sum_in),
    .best_sad   (best_sad),
    .best_mvx   (best_mvx),
    .best_mvy   (best_mvy)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               name, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic logic [31:0] sx(input logic [MV_W-1:0] v);
    return {{(32-MV_W){v[MV_W-1]}}, v};
  endfunction

  function automatic int raster_x(input int idx);
    return -RANGE + (idx % SIDE);
  endfunction

  function automatic int raster_y(input int idx);
    return -RANGE + (idx / SIDE);
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  // SAD landscape the emulated adder tree returns for candidate idx.
  function automatic logic [SAD_W-1:0] sad_of(input int mode, input int idx);
    int x;
    int y;
    x = raster_x(idx);
    y = raster_y(idx);
    case (mode)
      0:       return SAD_W'(iabs(x - 1) + iabs(y + 1));
      1:       return SAD_W'(100);
      2:       return 16'hFFFF;
      3:       return (x == 1 && y == 1) ? SAD_W'(3) : SAD_W'(5);
      default: return SAD_W'(iabs(x + 1) + iabs(y) + 7);
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at the negedge of the cycle after done.
  task automatic run_search(input int mode, input int rdy_mode, input int start_pulse,
                            input bit hold, input logic [SAD_W-1:0] lit_sad,
                            input int lit_x, input int lit_y);
    logic [SAD_W-1:0] m_sad;
    int               m_idx;
    int               n;
    int               last;
    bit               finished;
    bit               exp_valid;
    bit               exp_done;
    int               acc_cyc [NCAND];

    m_sad = '0;
    m_idx = 0;
    for (int k = 0; k < NCAND; k++) begin
      if (k == 0 || sad_of(mode, k) < m_sad) begin
        m_sad = sad_of(mode, k);
        m_idx = k;
      end
    end

    start      = 1'b1;
    cand_ready = 1'b0;
    sum_in     = '0;
    n          = 0;
    last       = -1000;
    finished   = 1'b0;

    for (int c = 1; c <= 300 && !finished; c++) begin
      @(negedge clk);
      start     = hold || (c == start_pulse);
      exp_valid = (n < NCAND);
      exp_done  = (n == NCAND) && (c == last + P + 1);

      check("busy", 32'(busy), 32'd1);
      check("cand_valid", 32'(cand_valid), 32'(exp_valid));
      check("done", 32'(done), 32'(exp_done));
      if (exp_valid) begin
        check("cand_x", sx(cand_x), 32'(raster_x(n)));
        check("cand_y", sx(cand_y), 32'(raster_y(n)));
      end
      if (exp_done || done) begin
        check("best_sad", 32'(best_sad), 32'(m_sad));
        check("best_mvx", sx(best_mvx), 32'(raster_x(m_idx)));
        check("best_mvy", sx(best_mvy), 32'(raster_y(m_idx)));
        check("best_sad_lit", 32'(best_sad), 32'(lit_sad));
        check("best_mvx_lit", sx(best_mvx), 32'(lit_x));
        check("best_mvy_lit", sx(best_mvy), 32'(lit_y));
        finished = 1'b1;
      end

      cand_ready = (rdy_mode == 0) ? 1'b1 : 1'((c % 2) == 1);
      if (exp_valid && cand_ready) begin
        acc_cyc[n] = c;
        n++;
        last = c;
      end

      // Zero when no tag returns, so a spurious capture would corrupt the minimum.
      sum_in = '0;
      for (int k = 0; k < n; k++)
        if (acc_cyc[k] == c - P) sum_in = sad_of(mode, k);
    end

    check("search_finished", 32'(finished), 32'd1);
    check("accept_count", 32'(n), 32'(NCAND));

    @(negedge clk);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_done", 32'(done), 32'd0);
    check("idle_cand_valid", 32'(cand_valid), 32'd0);
    check("held_best_sad", 32'(best_sad), 32'(lit_sad));
    check("held_best_mvx", sx(best_mvx), 32'(lit_x));
    start      = hold;
    cand_ready = 1'b0;
    sum_in     = '0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    cand_ready = 1'b0;
    sum_in     = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_cand_valid", 32'(cand_valid), 32'd0);
    check("rst_cand_x", sx(cand_x), 32'd0);
    check("rst_cand_y", sx(cand_y), 32'd0);
    check("rst_best_sad", 32'(best_sad), 32'd0);
    check("rst_best_mvx", sx(best_mvx), 32'd0);
    check("rst_best_mvy", sx(best_mvy), 32'd0);
    rst = 1'b0;

    run_search(0, 0, 0, 1'b0, 16'd0,      1,  -1);
    run_search(1, 0, 0, 1'b0, 16'd100,   -2,  -2);
    run_search(2, 0, 0, 1'b0, 16'hFFFF,  -2,  -2);
    run_search(0, 1, 0, 1'b0, 16'd0,      1,  -1);
    run_search(3, 0, 0, 1'b0, 16'd3,      1,   1);
    run_search(0, 0, 3, 1'b0, 16'd0,      1,  -1);

    // Abort a search partway through issue.
    start = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    cand_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst        = 1'b0;
    cand_ready = 1'b0;
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_cand_valid", 32'(cand_valid), 32'd0);
    check("mid_rst_cand_x", sx(cand_x), 32'd0);
    check("mid_rst_cand_y", sx(cand_y), 32'd0);
    check("mid_rst_best_sad", 32'(best_sad), 32'd0);
    check("mid_rst_best_mvx", sx(best_mvx), 32'd0);
    check("mid_rst_best_mvy", sx(best_mvy), 32'd0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_rst_done", 32'(done), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
    end
    run_search(0, 0, 0, 1'b0, 16'd0, 1, -1);

    // Back-to-back searches with start held high throughout.
    run_search(0, 0, 0, 1'b1, 16'd0, 1, -1);
    run_search(4, 0, 0, 1'b0, 16'd7, -1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/me_search_ctrl.md
Name: me_search_ctrl

Overview:
- Full-search scheduler for the motion-estimation SAD datapath.
- Walks every candidate motion vector in the search window in raster order and issues one candidate per accepted cycle to the absolute-difference stage.
- Tracks in-flight candidates through the free-running SAD adder tree and keeps the minimum SAD and its vector.
- Pulses done when the window is exhausted and the pipeline has drained.

Parameters:
- RANGE, 16: search window is -RANGE..RANGE-1 on each axis, giving (2*RANGE)^2 candidates.
- MV_W, 6: signed vector component width; must hold -RANGE..RANGE-1.
- SAD_W, 16: width of the SAD value from the adder tree.
- PIPE_LAT, 6: cycles from an accepted issue to its SAD on sum_in (1 AD stage + 5 adder-tree stages).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a search; sampled only in IDLE
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse; best_* are final in this cycle
- cand_valid  out  1  candidate offered to the AD stage
- cand_ready  in  1  AD stage accepts the candidate this cycle
- cand_x  out  MV_W  signed candidate horizontal offset
- cand_y  out  MV_W  signed candidate vertical offset
- sum_in  in  SAD_W  SAD from the adder tree; carries no valid signal
- best_sad  out  SAD_W  minimum SAD so far
- best_mvx  out  MV_W  horizontal vector of best_sad
- best_mvy  out  MV_W  vertical vector of best_sad

Behaviour:
- Reset values:
  - busy, done and cand_valid are 0.
  - cand_x and cand_y are 0.
  - best_sad, best_mvx and best_mvy are 0.
  - The state is IDLE and the tag delay line is cleared.
- Reset mid-search drops all in-flight tags. No done pulse follows.
- FSM states: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - On start=1, go to ISSUE and set busy=1.
  - Set cand_x and cand_y to -RANGE.
  - Set cand_valid=1.
  - Set the first-result flag.
- ISSUE:
  - A candidate is accepted when cand_valid && cand_ready.
  - On acceptance, cand_x increments.
  - When cand_x is RANGE-1, cand_x wraps to -RANGE and cand_y increments.
  - When the accepted candidate is (RANGE-1, RANGE-1), deassert cand_valid and go to DRAIN.
  - With cand_ready=0, the candidate is held stable and nothing is inserted into the delay line (a bubble).
- Tag delay line:
  - PIPE_LAT stages, each holding {valid, x, y}.
  - Every cycle it shifts in {accept, cand_x, cand_y}.
  - It never stalls, because the adder tree is free-running.
- Result capture:
  - A tag exiting with valid=1 pairs with sum_in in that cycle.
  - If the first-result flag is set, or sum_in < best_sad (strict), load best_sad, best_mvx and best_mvy, then clear the flag.
  - Ties keep the earlier raster-order candidate.
  - SAD compare is unsigned, full SAD_W.
- DRAIN: when the delay line holds no valid tag and the last capture has been written, go to DONE.
- DONE:
  - done=1 for exactly one cycle; busy stays 1 in this cycle.
  - Next state is IDLE; busy goes to 0 on entering IDLE.
- Timing: if the last accept is at cycle T, its SAD is at sum_in in cycle T+PIPE_LAT and done is high in cycle T+PIPE_LAT+1.
- start outside IDLE is ignored.
- start held high in IDLE after DONE begins a new search immediately.
- best_* hold their values between searches.
- Candidates issued per search: exactly (2*RANGE)^2, with no duplicates or skips regardless of the cand_ready pattern.

Decomposition:
- Package me_pkg:
  - SAD_W, MV_W and PIPE_LAT defaults.
  - State enum (IDLE, ISSUE, DRAIN, DONE).
  - A tag struct {valid, x, y}.
- Sub-module me_tag_delay: parameterised PIPE_LAT shift register of tags with synchronous reset, plus an any_valid output used by the DRAIN exit.

Test Plan:
- RANGE=2, cand_ready=1, model SAD=|x-1|+|y+1| -> 16 accepts on consecutive cycles; best_sad=0, best_mv=(1,-1); done at T+PIPE_LAT+1 with T = 16th accept cycle.
- RANGE=2, constant SAD=100 -> best_sad=100, best_mv=(-2,-2) (tie keeps first); all SAD=0xFFFF -> best_sad=0xFFFF, best_mv=(-2,-2).
- RANGE=2, cand_ready toggling 1/0 each cycle, same model as the first test -> same result; exactly 16 accepts in raster order; cand_x/cand_y stable while ready=0.
- RANGE=2, minimum only at last candidate (1,1), SAD=5 elsewhere, 3 there -> best_mv=(1,1), best_sad=3; proves DRAIN waits for the final tag.
- start pulsed during ISSUE -> ignored, still 16 accepts. rst asserted mid-ISSUE -> next cycle all outputs 0, no done; a new start completes normally.
- Back-to-back searches with start held high -> second search re-initialises best and reports its own minimum independently of the first.
